// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the NoC network adapters.
//   - flit field layout (type / VC id / payload) and flit type codes
//   - bit positions of the fields carried in a request tail payload
//   - VC count and VC id width
//   - request-path state encoding
//   - vc_onehot(): VC id to one-hot VC mask
package noc_pkg;

    localparam int NOC_FLIT_W  = 37;
    localparam int NOC_DATA_W  = 32;
    localparam int NOC_NUM_VC  = 8;
    localparam int NOC_VC_W    = 3;

    // Flit layout: [36:35] type, [34:32] VC id, [31:0] payload
    localparam int FLIT_TYPE_HI    = 36;
    localparam int FLIT_TYPE_LO    = 35;
    localparam int FLIT_VC_HI      = 34;
    localparam int FLIT_VC_LO      = 32;
    localparam int FLIT_PAYLOAD_HI = 31;

    typedef enum logic [1:0] {
        FLIT_ILLEGAL = 2'b00,
        FLIT_HDR     = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_type_e;

    // Tail payload: [7:5] prot, [4] write, [3:0] wstrb, [31:8] unused
    localparam int TAIL_STRB_LO = 0;
    localparam int TAIL_STRB_HI = 3;
    localparam int TAIL_WRITE   = 4;
    localparam int TAIL_PROT_LO = 5;
    localparam int TAIL_PROT_HI = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_BODY     = 3'd2,
        ST_ISSUE_WR = 3'd3,
        ST_ISSUE_RD = 3'd4,
        ST_WAIT     = 3'd5
    } req_state_e;

    function automatic logic [NOC_NUM_VC-1:0] vc_onehot(input logic [NOC_VC_W-1:0] vc);
        logic [NOC_NUM_VC-1:0] mask;
        mask = '0;
        mask[vc] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/sna_flit_decoder.sv
// sna_flit_decoder: purely combinational split of a NoC flit.
// Ports:
//   flit       in   raw flit
//   vc         out  VC id field
//   payload    out  32-bit payload field
//   is_header  out  type field is header
//   is_body    out  type field is body
//   is_tail    out  type field is tail
// The illegal type (00) asserts none of the is_* flags.
module sna_flit_decoder
    import noc_pkg::*;
#(
    parameter int FLIT_W = 37
)(
    input  logic [FLIT_W-1:0]   flit,
    output logic [NOC_VC_W-1:0] vc,
    output logic [FLIT_W-6:0]   payload,
    output logic                is_header,
    output logic                is_body,
    output logic                is_tail
);

    flit_type_e ftype;

    assign ftype     = flit_type_e'(flit[FLIT_W-1 -: 2]);
    assign vc        = flit[FLIT_W-3 -: NOC_VC_W];
    assign payload   = flit[FLIT_W-6:0];
    assign is_header = (ftype == FLIT_HDR);
    assign is_body   = (ftype == FLIT_BODY);
    assign is_tail   = (ftype == FLIT_TAIL);

endmodule

// File: rtl/sna_request.sv
// sna_request: slave-side network adapter, request path.
// Reassembles a request packet arriving as flits (header+tail = read,
// header+body+tail = write), issues it on the AXI4-Lite AW/W or AR
// channel and then waits for the response block to report completion.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   noc_data, is_valid         incoming flit and its valid
//   is_on_off                  per-VC credit (1 = VC may send)
//   aw*/w*/ar*                 AXI4-Lite request channels to the slave
//   req_write, req_vc          issued request kind and return VC
//   rsp_done                   response-sent pulse from response block
//   protocol_error             one-cycle pulse per dropped/illegal flit
module sna_request
    import noc_pkg::*;
#(
    parameter int FLIT_W = 37,
    parameter int DATA_W = 32,
    parameter int NUM_VC = 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [FLIT_W-1:0]   noc_data,
    input  logic                is_valid,
    output logic [NUM_VC-1:0]   is_on_off,
    output logic [DATA_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   araddr,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    output logic                req_write,
    output logic [NOC_VC_W-1:0] req_vc,
    input  logic                rsp_done,
    output logic                protocol_error
);

    // ---------------- flit decode ----------------
    logic [NOC_VC_W-1:0] dec_vc;
    logic [FLIT_W-6:0]   dec_payload;
    logic                dec_is_header;
    logic                dec_is_body;
    logic                dec_is_tail;
    logic [NUM_VC-1:0]   dec_vc_onehot;

    sna_flit_decoder #(.FLIT_W(FLIT_W)) u_decoder (
        .flit      (noc_data),
        .vc        (dec_vc),
        .payload   (dec_payload),
        .is_header (dec_is_header),
        .is_body   (dec_is_body),
        .is_tail   (dec_is_tail)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc_onehot
            assign dec_vc_onehot[gi] = (dec_vc == NOC_VC_W'(gi));
        end
    endgenerate

    // ---------------- state ----------------
    req_state_e            state_reg,          state_next;
    logic [NOC_VC_W-1:0]   owner_reg,          owner_next;
    logic [DATA_W-1:0]     addr_reg,           addr_next;
    logic [DATA_W-1:0]     wdata_reg,          wdata_next;
    logic [DATA_W/8-1:0]   wstrb_reg,          wstrb_next;
    logic [2:0]            prot_reg,           prot_next;
    logic                  awvalid_reg,        awvalid_next;
    logic                  wvalid_reg,         wvalid_next;
    logic                  arvalid_reg,        arvalid_next;
    logic                  aw_done_reg,        aw_done_next;
    logic                  w_done_reg,         w_done_next;
    logic                  got_body_reg,       got_body_next;
    logic                  req_write_reg,      req_write_next;
    logic [NOC_VC_W-1:0]   req_vc_reg,         req_vc_next;
    logic                  protocol_error_reg, protocol_error_next;
    logic [NUM_VC-1:0]     is_on_off_reg,      is_on_off_next;

    // A flit is only legal on a VC whose credit is currently on. While a
    // packet is being assembled only the owner VC is on, and during
    // issue/wait every VC is off, so this single test also rejects
    // foreign-VC flits and anything arriving after the tail.
    logic flit_on;
    logic flit_off;
    logic tail_write;
    logic aw_hs;
    logic w_hs;

    assign flit_on    = is_valid &  is_on_off_reg[dec_vc];
    assign flit_off   = is_valid & ~is_on_off_reg[dec_vc];
    assign tail_write = dec_payload[TAIL_WRITE];
    assign aw_hs      = awvalid_reg & awready;
    assign w_hs       = wvalid_reg & wready;

    always_comb begin
        state_next          = state_reg;
        owner_next          = owner_reg;
        addr_next           = addr_reg;
        wdata_next          = wdata_reg;
        wstrb_next          = wstrb_reg;
        prot_next           = prot_reg;
        awvalid_next        = awvalid_reg;
        wvalid_next         = wvalid_reg;
        arvalid_next        = arvalid_reg;
        aw_done_next        = aw_done_reg;
        w_done_next         = w_done_reg;
        got_body_next       = got_body_reg;
        req_write_next      = req_write_reg;
        req_vc_next         = req_vc_reg;
        protocol_error_next = flit_off;
        is_on_off_next      = is_on_off_reg;

        unique case (state_reg)
            ST_IDLE: begin
                is_on_off_next = '1;
                if (flit_on) begin
                    if (dec_is_header) begin
                        addr_next      = dec_payload;
                        owner_next     = dec_vc;
                        got_body_next  = 1'b0;
                        is_on_off_next = dec_vc_onehot;
                        state_next     = ST_HDR;
                    end else begin
                        protocol_error_next = 1'b1;
                    end
                end
            end

            // HDR and BODY share one decision: got_body records which of
            // the two we are in, and the tail's write bit must agree with
            // it (write packets carry a body, reads do not).
            ST_HDR, ST_BODY: begin
                if (flit_on) begin
                    if (dec_is_body && !got_body_reg) begin
                        wdata_next    = dec_payload;
                        got_body_next = 1'b1;
                        state_next    = ST_BODY;
                    end else if (dec_is_tail && (tail_write == got_body_reg)) begin
                        prot_next      = dec_payload[TAIL_PROT_HI:TAIL_PROT_LO];
                        req_write_next = got_body_reg;
                        req_vc_next    = owner_reg;
                        is_on_off_next = '0;
                        if (got_body_reg) begin
                            wstrb_next   = dec_payload[TAIL_STRB_HI:TAIL_STRB_LO];
                            awvalid_next = 1'b1;
                            wvalid_next  = 1'b1;
                            aw_done_next = 1'b0;
                            w_done_next  = 1'b0;
                            state_next   = ST_ISSUE_WR;
                        end else begin
                            arvalid_next = 1'b1;
                            state_next   = ST_ISSUE_RD;
                        end
                    end else begin
                        protocol_error_next = 1'b1;
                        is_on_off_next      = '1;
                        state_next          = ST_IDLE;
                    end
                end
            end

            ST_ISSUE_WR: begin
                if (aw_hs) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = ST_WAIT;
                end
            end

            ST_ISSUE_RD: begin
                if (arvalid_reg && arready) begin
                    arvalid_next = 1'b0;
                    state_next   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (rsp_done) begin
                    is_on_off_next = '1;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                is_on_off_next = '1;
                state_next     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            owner_reg          <= '0;
            addr_reg           <= '0;
            wdata_reg          <= '0;
            wstrb_reg          <= '0;
            prot_reg           <= '0;
            awvalid_reg        <= 1'b0;
            wvalid_reg         <= 1'b0;
            arvalid_reg        <= 1'b0;
            aw_done_reg        <= 1'b0;
            w_done_reg         <= 1'b0;
            got_body_reg       <= 1'b0;
            req_write_reg      <= 1'b0;
            req_vc_reg         <= '0;
            protocol_error_reg <= 1'b0;
            is_on_off_reg      <= '1;
        end else begin
            state_reg          <= state_next;
            owner_reg          <= owner_next;
            addr_reg           <= addr_next;
            wdata_reg          <= wdata_next;
            wstrb_reg          <= wstrb_next;
            prot_reg           <= prot_next;
            awvalid_reg        <= awvalid_next;
            wvalid_reg         <= wvalid_next;
            arvalid_reg        <= arvalid_next;
            aw_done_reg        <= aw_done_next;
            w_done_reg         <= w_done_next;
            got_body_reg       <= got_body_next;
            req_write_reg      <= req_write_next;
            req_vc_reg         <= req_vc_next;
            protocol_error_reg <= protocol_error_next;
            is_on_off_reg      <= is_on_off_next;
        end
    end

    // Address and protection are shared by both channels; only the
    // relevant valid is ever raised.
    assign is_on_off      = is_on_off_reg;
    assign awaddr         = addr_reg;
    assign araddr         = addr_reg;
    assign awprot         = prot_reg;
    assign arprot         = prot_reg;
    assign awvalid        = awvalid_reg;
    assign wdata          = wdata_reg;
    assign wstrb          = wstrb_reg;
    assign wvalid         = wvalid_reg;
    assign arvalid        = arvalid_reg;
    assign req_write      = req_write_reg;
    assign req_vc         = req_vc_reg;
    assign protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_sna_request.sv
// tb_sna_request: randomized + directed bench for sna_request.
// Expected AXI requests are pushed into queues as packets are sent; a
// monitor pops and compares them on each AXI handshake.
module tb_sna_request;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [36:0] noc_data;
    logic        is_valid;
    logic [7:0]  is_on_off;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, arvalid, arready;
    logic [3:0]  wstrb;
    logic        req_write;
    logic [2:0]  req_vc;
    logic        rsp_done;
    logic        protocol_error;

    always #5 clk = ~clk;

    sna_request dut (
        .clk(clk), .rst(rst), .noc_data(noc_data), .is_valid(is_valid),
        .is_on_off(is_on_off),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .req_write(req_write), .req_vc(req_vc), .rsp_done(rsp_done),
        .protocol_error(protocol_error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int err_exp = 0;
    int err_seen = 0;
    bit rand_ready = 1'b0;

    logic [34:0] exp_rd[$];   // {addr, prot}
    logic [34:0] exp_aw[$];   // {addr, prot}
    logic [35:0] exp_w[$];    // {data, strb}
    logic [3:0]  exp_req[$];  // {write, vc}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [1:0] t, input logic [2:0] vc, input logic [31:0] pl);
        noc_data = {t, vc, pl};
        is_valid = 1'b1;
        tick();
        is_valid = 1'b0;
        noc_data = {5'($urandom), 32'($urandom)};   // junk while not valid
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_valids"}, {awvalid, wvalid, arvalid}, 3'b000);
        check({name, "_addr"}, {awaddr, araddr}, 64'h0);
        check({name, "_wdata_strb"}, {wdata, wstrb}, 36'h0);
        check({name, "_prot"}, {awprot, arprot}, 6'h0);
        check({name, "_req"}, {req_write, req_vc}, 4'h0);
        check({name, "_perr"}, protocol_error, 1'b0);
        check({name, "_on_off"}, is_on_off, 8'hFF);
    endtask

    // Send one packet. fvc >= 0 injects a flit on that foreign VC after
    // the header (dropped with an error, packet continues).
    task automatic do_packet(input bit wr, input logic [2:0] vc, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int fvc);
        logic [7:0] own;
        own = 8'(1 << vc);
        send_flit(FLIT_HDR, vc, addr);
        check("hdr_on_off", is_on_off, own);
        if (fvc >= 0) begin
            rsp_done = 1'($urandom);        // rsp_done outside WAIT must be ignored
            send_flit(2'($urandom_range(0, 3)), 3'(fvc), $urandom);
            rsp_done = 1'b0;
            err_exp++;
            check("foreign_perr", protocol_error, 1'b1);
            check("foreign_on_off", is_on_off, own);
        end
        if (wr) begin
            send_flit(FLIT_BODY, vc, data);
            check("body_on_off", is_on_off, own);
            exp_aw.push_back({addr, prot});
            exp_w.push_back({data, strb});
            exp_req.push_back({1'b1, vc});
            send_flit(FLIT_TAIL, vc, {24'($urandom), prot, 1'b1, strb});
            check("wr_issue_valids", {awvalid, wvalid, arvalid}, 3'b110);
        end else begin
            exp_rd.push_back({addr, prot});
            exp_req.push_back({1'b0, vc});
            send_flit(FLIT_TAIL, vc, {24'($urandom), prot, 1'b0, 4'($urandom)});
            check("rd_issue_valids", {awvalid, wvalid, arvalid}, 3'b001);
        end
        check("tail_on_off", is_on_off, 8'h00);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((awvalid || wvalid || arvalid) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drain"}, {awvalid, wvalid, arvalid}, 3'b000);
    endtask

    task automatic complete(input int delay);
        repeat (delay) tick();
        check("wait_on_off", is_on_off, 8'h00);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("rsp_on_off", is_on_off, 8'hFF);
    endtask

    // Random readies, updated slightly after the main process drives.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                awready = 1'($urandom);
                wready  = 1'($urandom);
                arready = 1'($urandom);
            end
        end
    end

    // Monitor: handshakes, valid stability, protocol_error pulses.
    initial begin
        logic        p_aw, p_w, p_ar, p_rst;
        logic [34:0] p_awpl, p_arpl;
        logic [35:0] p_wpl;
        p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0; p_rst = 1'b1;
        p_awpl = '0; p_arpl = '0; p_wpl = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (protocol_error) err_seen++;
                if (!p_rst) begin
                    if (p_aw) check("aw_hold", {awvalid, awaddr, awprot}, {1'b1, p_awpl});
                    if (p_w)  check("w_hold",  {wvalid, wdata, wstrb},   {1'b1, p_wpl});
                    if (p_ar) check("ar_hold", {arvalid, araddr, arprot}, {1'b1, p_arpl});
                end
                if (arvalid && arready) begin
                    if (exp_rd.size() == 0 || exp_req.size() == 0)
                        check("ar_unexpected", 1'b1, 1'b0);
                    else begin
                        check("ar_payload", {araddr, arprot}, exp_rd.pop_front());
                        check("ar_req", {req_write, req_vc}, exp_req.pop_front());
                    end
                end
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0 || exp_req.size() == 0)
                        check("aw_unexpected", 1'b1, 1'b0);
                    else begin
                        check("aw_payload", {awaddr, awprot}, exp_aw.pop_front());
                        check("aw_req", {req_write, req_vc}, exp_req.pop_front());
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0)
                        check("w_unexpected", 1'b1, 1'b0);
                    else
                        check("w_payload", {wdata, wstrb}, exp_w.pop_front());
                end
            end
            p_aw = awvalid && !awready; p_awpl = {awaddr, awprot};
            p_w  = wvalid  && !wready;  p_wpl  = {wdata, wstrb};
            p_ar = arvalid && !arready; p_arpl = {araddr, arprot};
            p_rst = rst;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fvc;
        logic [1:0] stray;
        rst = 1'b1; is_valid = 1'b0; noc_data = '0; rsp_done = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_values("reset");

        // Read on VC2, arready after 3 cycles
        do_packet(1'b0, 3'd2, 32'h0000_1000, 32'h0, 4'h0, 3'b010, -1);
        $display("txn read vc2 addr 0x1000 issued");
        check("rd_araddr", {araddr, arprot}, {32'h0000_1000, 3'b010});
        repeat (3) tick();
        check("rd_held", arvalid, 1'b1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rd_ar_drop", arvalid, 1'b0);
        check("rd_req", {req_write, req_vc}, {1'b0, 3'd2});
        complete(1);

        // Write on VC5, wready in cycle 1, awready in cycle 4
        do_packet(1'b1, 3'd5, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 3'b000, -1);
        $display("txn write vc5 addr 0x2000 skewed readies");
        check("wr_data", {wdata, wstrb}, {32'hDEAD_BEEF, 4'hF});
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("wr_w_first", {awvalid, wvalid}, 2'b10);
        repeat (2) tick();
        check("wr_aw_held", {awvalid, wvalid}, 2'b10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("wr_both_done", {awvalid, wvalid}, 2'b00);
        complete(0);

        // Simultaneous handshake
        awready = 1'b1; wready = 1'b1;
        do_packet(1'b1, 3'd0, 32'h0000_3000, 32'h1234_5678, 4'h5, 3'b101, -1);
        $display("txn write vc0 simultaneous handshake");
        tick();
        check("sim_one_cycle", {awvalid, wvalid}, 2'b00);
        awready = 1'b0; wready = 1'b0;
        complete(0);

        // Body in IDLE
        err_exp++;
        send_flit(FLIT_BODY, 3'd0, 32'hAAAA_0000);
        $display("txn body in idle");
        check("idle_body_perr", protocol_error, 1'b1);
        check("idle_body_on_off", is_on_off, 8'hFF);
        tick();
        check("perr_pulse", protocol_error, 1'b0);

        // Header then tail(write=1) without body
        send_flit(FLIT_HDR, 3'd1, 32'h0000_4000);
        send_flit(FLIT_TAIL, 3'd1, {24'h0, 3'b000, 1'b1, 4'hF});
        err_exp++;
        $display("txn write tail without body");
        check("nobody_perr", protocol_error, 1'b1);
        check("nobody_on_off", is_on_off, 8'hFF);
        check("nobody_valids", {awvalid, wvalid, arvalid}, 3'b000);
        tick();
        check("nobody_valids2", {awvalid, wvalid, arvalid}, 3'b000);

        // Foreign VC during assembly; packet still completes
        rand_ready = 1'b1;
        do_packet(1'b0, 3'd1, 32'h0000_5000, 32'h0, 4'h0, 3'b001, 3);
        $display("txn read vc1 with foreign vc3 flit");
        drain("foreign");
        complete(1);
        check("err_count_directed", err_seen, err_exp);

        // Reset mid-packet
        rand_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        send_flit(FLIT_HDR, 3'd4, 32'h0000_6000);
        send_flit(FLIT_BODY, 3'd4, 32'hCAFE_F00D);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("txn reset mid-packet");
        check_reset_values("midrst");
        rand_ready = 1'b1;
        do_packet(1'b0, 3'd6, 32'h0000_7000, 32'h0, 4'h0, 3'b011, -1);
        drain("after_rst");
        complete(0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       stray = 2'b00;
                    1:       stray = 2'b10;
                    default: stray = 2'b11;
                endcase
                err_exp++;
                send_flit(stray, 3'($urandom), $urandom);
                check("rand_stray_perr", protocol_error, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                rsp_done = 1'b1;
                tick();
                rsp_done = 1'b0;
                check("rand_idle_rsp_on_off", is_on_off, 8'hFF);
            end
            fvc = -1;
            if ($urandom_range(0, 3) == 0) fvc = $urandom_range(0, 7);
            begin
                bit          wr;
                logic [2:0]  vc;
                logic [31:0] addr, data;
                logic [3:0]  strb;
                logic [2:0]  prot;
                wr = 1'($urandom); vc = 3'($urandom);
                addr = $urandom; data = $urandom;
                strb = 4'($urandom); prot = 3'($urandom);
                if (fvc == int'(vc)) fvc = int'(vc + 3'd1);
                do_packet(wr, vc, addr, data, strb, prot, fvc);
                $display("txn rand %0d %s vc%0d addr 0x%08h", i, wr ? "write" : "read", vc, addr);
            end
            drain("rand");
            complete($urandom_range(0, 3));
        end

        rand_ready = 1'b0;
        repeat (3) tick();
        check("queues_empty", exp_rd.size() + exp_aw.size() + exp_w.size() + exp_req.size(), 0);
        check("err_count_final", err_seen, err_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sna_request.md
Name: sna_request

Overview:
- Slave-side network adapter, request path.
- Receives request packets from the NoC as 37-bit flits under per-VC on/off flow control.
- Reassembles each packet: header + tail for a read, header + body + tail for a write.
- Issues the request on the AXI4-Lite AW/W or AR channels of the attached slave, then holds until the response-path block reports completion.

Parameters:
- FLIT_W, 37, flit width: [36:35] type, [34:32] VC id, [31:0] payload.
- DATA_W, 32, AXI address and data width.
- NUM_VC, 8, number of virtual channels (width of is_on_off).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- noc_data  in  37  incoming flit.
- is_valid  in  1  noc_data is valid this cycle.
- is_on_off  out  8  per-VC credit; 1 = VC may send.
- awaddr  out  32  write address.
- awprot  out  3  write protection.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- wdata  out  32  write data.
- wstrb  out  4  write strobes.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- araddr  out  32  read address.
- arprot  out  3  read protection.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- req_write  out  1  issued request is a write (to response block).
- req_vc  out  3  VC on which the response must return.
- rsp_done  in  1  one-cycle pulse from response block: response sent.
- protocol_error  out  1  one-cycle pulse on a dropped or illegal flit.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all valids 0, addr/data/strb/prot 0, req_write 0, req_vc 0, protocol_error 0, is_on_off 8'hFF, state IDLE.
- Flit types: 01 header, 10 body, 11 tail, 00 illegal.
- Payloads:
  - Header payload = address.
  - Body payload = wdata.
  - Tail payload: [4] write, [3:0] wstrb, [7:5] prot; [31:8] ignored.
- All outputs are registered.
- A flit is accepted only when is_valid=1.

State machine:
- IDLE:
  - is_on_off=8'hFF.
  - A header on VC v: capture address, owner<=v, is_on_off<=one-hot(v), go to HDR.
  - Any other type: drop, pulse protocol_error, stay in IDLE.
- HDR (owner VC only):
  - Body: capture wdata, got_body<=1, go to BODY.
  - Tail with write=0: go to ISSUE_RD.
  - Tail with write=1: abort to IDLE with protocol_error.
  - Header: abort to IDLE with protocol_error.
- BODY:
  - Tail with write=1: capture wstrb/prot, go to ISSUE_WR.
  - Tail with write=0, or any other flit: abort to IDLE with protocol_error.
- Foreign-VC flits in HDR/BODY: dropped, protocol_error pulse, state unchanged.
- Issue latency: tail accepted at edge N -> valid asserted after edge N; is_on_off=8'h00 from the same edge.
- ISSUE_WR:
  - awvalid and wvalid rise together.
  - Each drops independently on its own handshake (valid&ready).
  - Leave to WAIT when both handshakes are done; simultaneous and skewed completion are both legal.
  - Track completion with aw_done/w_done flags.
- ISSUE_RD: arvalid held until arready, then go to WAIT.
- Valid stability: once asserted, a valid and its payload are held stable until handshake (AXI rule).
- WAIT:
  - req_write/req_vc held.
  - On rsp_done go to IDLE, with is_on_off=8'hFF next cycle.
  - rsp_done outside WAIT is ignored.
- Upstream contract: the router honours is_on_off the cycle after it changes. A flit on an off VC is dropped with protocol_error.
- Reset mid-packet: partial packet discarded; no AXI valid remains asserted after the reset edge.

Decomposition:
- Shared package noc_pkg:
  - Flit field indices and type codes (FLIT_HDR/BODY/TAIL).
  - Tail bit positions.
  - NUM_VC, VC id width.
  - State encoding (IDLE, HDR, BODY, ISSUE_WR, ISSUE_RD, WAIT).
- Optional sub-module sna_flit_decoder: combinational split of a flit into type, vc and payload, plus is_header/is_body/is_tail. Reusable by the master-side response receiver.

Test Plan:
- Read:
  - Stimulus: header(VC2, addr 0x0000_1000), then tail(write=0, prot=3'b010).
  - Required response: is_on_off=8'h04 after header, 8'h00 after tail; araddr=0x1000, arvalid=1 one cycle after tail.
  - Stimulus: arready after 3 cycles, then rsp_done.
  - Required response: is_on_off back to 8'hFF the cycle after rsp_done; req_vc=2, req_write=0.
- Write, skewed readies:
  - Stimulus: header(VC5, 0x2000), body(0xDEADBEEF), tail(write=1, strb=4'hF); wready in cycle 1, awready in cycle 4.
  - Required response: wvalid drops after cycle 1, awvalid after cycle 4, then WAIT; wdata=0xDEADBEEF, wstrb=4'hF.
- Simultaneous handshake: awready=wready=1 from the first cycle -> both valids high exactly one cycle, WAIT next.
- Protocol errors:
  - Stimulus: body in IDLE. Required response: protocol_error pulse, state stays IDLE.
  - Stimulus: header(VC1) then tail(write=1) with no body. Required response: protocol_error, no AXI valid asserted.
  - Stimulus: header(VC1) then flit on VC3. Required response: protocol_error, packet on VC1 still completes.
- Reset mid-packet: rst pulsed after header+body -> all outputs at reset values next cycle; a fresh read then completes normally.
